// File: rtl/crc16_ccitt_frame_checker.sv
// Receive-side CRC-16/CCITT frame checker: strips the trailing two CRC bytes, forwards payload, reports per-frame result.
// Optional error-frame counter is enabled by defining CRC_CHK_ERR_CNT_EN.
module crc16_ccitt_frame_checker #(
    parameter logic [15:0] INIT_VALUE = 16'hFFFF,
    parameter int unsigned MAX_LEN    = 1024,
    parameter int unsigned LEN_W      = 11
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sync_reset_i,
    input  logic             rx_valid_i,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_sof_i,
    input  logic             rx_eof_i,
    output logic             pl_valid_o,
    output logic [7:0]       pl_data_o,
    output logic             frame_done_o,
    output logic             frame_ok_o,
    output logic [1:0]       frame_err_o,
    output logic [LEN_W-1:0] frame_len_o,
    output logic [15:0]      crc_rcv_o,
    output logic [15:0]      crc_calc_o,
    output logic [15:0]      err_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL1  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DROP   = 2'd3
    } state_t;

    localparam logic [1:0]       ERR_NONE  = 2'b00;
    localparam logic [1:0]       ERR_RUNT  = 2'b01;
    localparam logic [1:0]       ERR_OVER  = 2'b10;
    localparam logic [1:0]       ERR_ABORT = 2'b11;
    localparam logic [LEN_W-1:0] LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_OVF   = LEN_W'(MAX_LEN + 1);

    // MSB-first CRC-16 (poly 0x1021) advanced by one byte, no reflection.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data_in);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ data_in[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    state_t           state_q, state_d;
    logic [7:0]       h0_q, h0_d, h1_q, h1_d;
    logic [15:0]      crc_q, crc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             pl_valid_q, pl_valid_d;
    logic [7:0]       pl_data_q, pl_data_d;
    logic             done_q, done_d;
    logic             ok_q, ok_d;
    logic [1:0]       err_q, err_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [15:0]      crc_rcv_q, crc_rcv_d;
    logic [15:0]      crc_calc_q, crc_calc_d;

    logic             rep_s;
    logic             rep_ok_s;
    logic [1:0]       rep_err_s;
    logic [LEN_W-1:0] rep_len_s;
    logic [15:0]      rep_rcv_s;
    logic [15:0]      rep_calc_s;
    logic [15:0]      crc_upd_s;
    logic [LEN_W-1:0] cnt_inc_s;

    assign crc_upd_s = crc16_byte(crc_q, h1_q);
    assign cnt_inc_s = cnt_q + LEN_ONE;

    // Frame FSM next-state, delay line, CRC update and frame-result selection.
    always_comb begin
        state_d    = state_q;
        h0_d       = h0_q;
        h1_d       = h1_q;
        crc_d      = crc_q;
        cnt_d      = cnt_q;
        pl_valid_d = 1'b0;
        pl_data_d  = pl_data_q;
        rep_s      = 1'b0;
        rep_ok_s   = 1'b0;
        rep_err_s  = ERR_NONE;
        rep_len_s  = LEN_ZERO;
        rep_rcv_s  = 16'h0000;
        rep_calc_s = 16'h0000;

        if (rx_valid_i) begin
            if (rx_sof_i) begin
                // A sof that interrupts a frame reports the abort; a sof+eof on top of that is absorbed.
                if (state_q != ST_IDLE) begin
                    rep_s      = 1'b1;
                    rep_err_s  = ERR_ABORT;
                    rep_len_s  = cnt_q;
                    rep_rcv_s  = {h1_q, h0_q};
                    rep_calc_s = crc_q;
                end else if (rx_eof_i) begin
                    rep_s      = 1'b1;
                    rep_err_s  = ERR_RUNT;
                    rep_len_s  = LEN_ZERO;
                    rep_rcv_s  = {8'h00, rx_data_i};
                    rep_calc_s = INIT_VALUE;
                end else begin
                    rep_s = 1'b0;
                end
                h0_d    = rx_data_i;
                cnt_d   = LEN_ZERO;
                crc_d   = INIT_VALUE;
                state_d = rx_eof_i ? ST_IDLE : ST_FILL1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_d = ST_IDLE;
                    end
                    ST_FILL1: begin
                        if (rx_eof_i) begin
                            rep_s      = 1'b1;
                            rep_ok_s   = ({h0_q, rx_data_i} == crc_q);
                            rep_len_s  = cnt_q;
                            rep_rcv_s  = {h0_q, rx_data_i};
                            rep_calc_s = crc_q;
                            state_d    = ST_IDLE;
                        end else begin
                            h1_d    = h0_q;
                            h0_d    = rx_data_i;
                            state_d = ST_STREAM;
                        end
                    end
                    ST_STREAM: begin
                        if (cnt_q == LEN_MAX) begin
                            cnt_d = LEN_OVF;
                            if (rx_eof_i) begin
                                rep_s      = 1'b1;
                                rep_err_s  = ERR_OVER;
                                rep_len_s  = LEN_OVF;
                                rep_rcv_s  = {h0_q, rx_data_i};
                                rep_calc_s = crc_q;
                                state_d    = ST_IDLE;
                            end else begin
                                state_d = ST_DROP;
                            end
                        end else begin
                            pl_valid_d = 1'b1;
                            pl_data_d  = h1_q;
                            crc_d      = crc_upd_s;
                            cnt_d      = cnt_inc_s;
                            h1_d       = h0_q;
                            h0_d       = rx_data_i;
                            if (rx_eof_i) begin
                                rep_s      = 1'b1;
                                rep_ok_s   = ({h0_q, rx_data_i} == crc_upd_s);
                                rep_len_s  = cnt_inc_s;
                                rep_rcv_s  = {h0_q, rx_data_i};
                                rep_calc_s = crc_upd_s;
                                state_d    = ST_IDLE;
                            end else begin
                                state_d = ST_STREAM;
                            end
                        end
                    end
                    ST_DROP: begin
                        if (rx_eof_i) begin
                            rep_s      = 1'b1;
                            rep_err_s  = ERR_OVER;
                            rep_len_s  = cnt_q;
                            rep_rcv_s  = {h0_q, rx_data_i};
                            rep_calc_s = crc_q;
                            state_d    = ST_IDLE;
                        end else begin
                            state_d = ST_DROP;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // Result registers load only on a report and otherwise hold until the next one.
    always_comb begin
        done_d     = rep_s;
        ok_d       = ok_q;
        err_d      = err_q;
        len_d      = len_q;
        crc_rcv_d  = crc_rcv_q;
        crc_calc_d = crc_calc_q;
        if (rep_s) begin
            ok_d       = rep_ok_s;
            err_d      = rep_err_s;
            len_d      = rep_len_s;
            crc_rcv_d  = rep_rcv_s;
            crc_calc_d = rep_calc_s;
        end else begin
            ok_d = ok_q;
        end
    end

    // State and output registers with async and sync reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            h0_q       <= 8'h00;
            h1_q       <= 8'h00;
            crc_q      <= INIT_VALUE;
            cnt_q      <= LEN_ZERO;
            pl_valid_q <= 1'b0;
            pl_data_q  <= 8'h00;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= ERR_NONE;
            len_q      <= LEN_ZERO;
            crc_rcv_q  <= 16'h0000;
            crc_calc_q <= 16'h0000;
        end else if (sync_reset_i) begin
            state_q    <= ST_IDLE;
            h0_q       <= 8'h00;
            h1_q       <= 8'h00;
            crc_q      <= INIT_VALUE;
            cnt_q      <= LEN_ZERO;
            pl_valid_q <= 1'b0;
            pl_data_q  <= 8'h00;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= ERR_NONE;
            len_q      <= LEN_ZERO;
            crc_rcv_q  <= 16'h0000;
            crc_calc_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            h0_q       <= h0_d;
            h1_q       <= h1_d;
            crc_q      <= crc_d;
            cnt_q      <= cnt_d;
            pl_valid_q <= pl_valid_d;
            pl_data_q  <= pl_data_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            len_q      <= len_d;
            crc_rcv_q  <= crc_rcv_d;
            crc_calc_q <= crc_calc_d;
        end
    end

    assign pl_valid_o   = pl_valid_q;
    assign pl_data_o    = pl_data_q;
    assign frame_done_o = done_q;
    assign frame_ok_o   = ok_q;
    assign frame_err_o  = err_q;
    assign frame_len_o  = len_q;
    assign crc_rcv_o    = crc_rcv_q;
    assign crc_calc_o   = crc_calc_q;

`ifdef CRC_CHK_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    // Saturating count of failed frame reports.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (rep_s && !rep_ok_s && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_q <= 16'h0000;
        end else if (sync_reset_i) begin
            err_cnt_q <= 16'h0000;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_crc16_ccitt_frame_checker.sv
// Directed bench for crc16_ccitt_frame_checker: a default instance plus a MAX_LEN=4 instance share one stimulus stream.
module tb_crc16_ccitt_frame_checker;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sync_reset = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_sof = 1'b0;
    logic        rx_eof = 1'b0;

    logic        b_pl_valid, b_done, b_ok;
    logic [7:0]  b_pl_data;
    logic [1:0]  b_err;
    logic [10:0] b_len;
    logic [15:0] b_rcv, b_calc, b_err_cnt;

    logic        s_pl_valid, s_done, s_ok;
    logic [7:0]  s_pl_data;
    logic [1:0]  s_err;
    logic [2:0]  s_len;
    logic [15:0] s_rcv, s_calc, s_err_cnt;

    int checks = 0;
    int failures = 0;
    int b_done_cnt = 0;
    int b_ok_cnt = 0;
    logic [7:0] b_pl_q[$];
    logic [7:0] s_pl_q[$];
    logic [7:0] msg[9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    crc16_ccitt_frame_checker u_big (
        .clk(clk), .reset_n(reset_n), .sync_reset_i(sync_reset),
        .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_sof_i(rx_sof), .rx_eof_i(rx_eof),
        .pl_valid_o(b_pl_valid), .pl_data_o(b_pl_data), .frame_done_o(b_done),
        .frame_ok_o(b_ok), .frame_err_o(b_err), .frame_len_o(b_len),
        .crc_rcv_o(b_rcv), .crc_calc_o(b_calc), .err_cnt_o(b_err_cnt)
    );

    crc16_ccitt_frame_checker #(.MAX_LEN(4), .LEN_W(3)) u_small (
        .clk(clk), .reset_n(reset_n), .sync_reset_i(sync_reset),
        .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_sof_i(rx_sof), .rx_eof_i(rx_eof),
        .pl_valid_o(s_pl_valid), .pl_data_o(s_pl_data), .frame_done_o(s_done),
        .frame_ok_o(s_ok), .frame_err_o(s_err), .frame_len_o(s_len),
        .crc_rcv_o(s_rcv), .crc_calc_o(s_calc), .err_cnt_o(s_err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (b_pl_valid) b_pl_q.push_back(b_pl_data);
        if (s_pl_valid) s_pl_q.push_back(s_pl_data);
        if (b_done) begin
            b_done_cnt <= b_done_cnt + 1;
            if (b_ok) b_ok_cnt <= b_ok_cnt + 1;
        end
    end

    task automatic send(input logic [7:0] d, input logic s, input logic e);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = d;
        rx_sof   = s;
        rx_eof   = e;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_sof   = 1'b0;
            rx_eof   = 1'b0;
        end
    endtask

    task automatic wait_done(input bit use_small, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_sof   = 1'b0;
            rx_eof   = 1'b0;
            if (use_small ? s_done : b_done) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({b_pl_valid, b_done, b_ok} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b want 000", {b_pl_valid, b_done, b_ok}); end
        checks++; if (b_err !== 2'b00 || b_len !== 11'd0) begin failures++; $display("FAIL reset_err_len: got err=%b len=%0d want 00/0", b_err, b_len); end
        checks++; if (b_rcv !== 16'h0000 || b_calc !== 16'h0000) begin failures++; $display("FAIL reset_crc: got rcv=%h calc=%h want 0000/0000", b_rcv, b_calc); end
        checks++; if (b_err_cnt !== 16'h0000) begin failures++; $display("FAIL reset_err_cnt: got %h want 0000", b_err_cnt); end
        reset_n = 1'b1;
        idle(2);
    endtask

    task automatic test_good_frame;
        bit seen;
        b_pl_q.delete();
        send(msg[0], 1'b1, 1'b0);
        for (int i = 1; i < 9; i++) send(msg[i], 1'b0, 1'b0);
        send(8'h29, 1'b0, 1'b0);
        send(8'hB1, 1'b0, 1'b1);
        wait_done(1'b0, seen);
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL good_done: got no frame_done want pulse"); end
        checks++; if (b_ok !== 1'b1 || b_err !== 2'b00) begin failures++; $display("FAIL good_ok: got ok=%b err=%b want 1/00", b_ok, b_err); end
        checks++; if (b_len !== 11'd9) begin failures++; $display("FAIL good_len: got %0d want 9", b_len); end
        checks++; if (b_calc !== 16'h29B1 || b_rcv !== 16'h29B1) begin failures++; $display("FAIL good_crc: got calc=%h rcv=%h want 29b1/29b1", b_calc, b_rcv); end
        @(negedge clk);
        checks++; if (b_done !== 1'b0 || b_ok !== 1'b1) begin failures++; $display("FAIL good_pulse_hold: got done=%b ok=%b want 0/1", b_done, b_ok); end
        checks++; if (b_pl_q.size() !== 9) begin failures++; $display("FAIL good_pl_count: got %0d want 9", b_pl_q.size()); end
        for (int i = 0; i < 9 && i < b_pl_q.size(); i++) begin
            checks++; if (b_pl_q[i] !== msg[i]) begin failures++; $display("FAIL good_pl_byte%0d: got %h want %h", i, b_pl_q[i], msg[i]); end
        end
    endtask

    task automatic test_bad_crc;
        bit seen;
        send(msg[0], 1'b1, 1'b0);
        for (int i = 1; i < 9; i++) send(msg[i], 1'b0, 1'b0);
        send(8'h29, 1'b0, 1'b0);
        send(8'hB0, 1'b0, 1'b1);
        wait_done(1'b0, seen);
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL bad_done: got no frame_done want pulse"); end
        checks++; if (b_ok !== 1'b0 || b_err !== 2'b00) begin failures++; $display("FAIL bad_ok: got ok=%b err=%b want 0/00", b_ok, b_err); end
        checks++; if (b_rcv !== 16'h29B0 || b_calc !== 16'h29B1) begin failures++; $display("FAIL bad_crc: got rcv=%h calc=%h want 29b0/29b1", b_rcv, b_calc); end
        idle(1);
    endtask

    task automatic test_zero_payload_and_runt;
        bit seen;
        b_pl_q.delete();
        send(8'hFF, 1'b1, 1'b0);
        send(8'hFF, 1'b0, 1'b1);
        wait_done(1'b0, seen);
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL zero_done: got no frame_done want pulse"); end
        checks++; if (b_ok !== 1'b1 || b_len !== 11'd0 || b_calc !== 16'hFFFF) begin failures++; $display("FAIL zero_result: got ok=%b len=%0d calc=%h want 1/0/ffff", b_ok, b_len, b_calc); end
        idle(1);
        checks++; if (b_pl_q.size() !== 0) begin failures++; $display("FAIL zero_no_pl: got %0d payload bytes want 0", b_pl_q.size()); end
        send(8'h55, 1'b1, 1'b1);
        wait_done(1'b0, seen);
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL runt_done: got no frame_done want pulse"); end
        checks++; if (b_err !== 2'b01 || b_ok !== 1'b0 || b_len !== 11'd0) begin failures++; $display("FAIL runt_result: got err=%b ok=%b len=%0d want 01/0/0", b_err, b_ok, b_len); end
        idle(1);
    endtask

    task automatic test_overlength;
        bit seen;
        logic [7:0] exp_b;
        s_pl_q.delete();
        send(8'h10, 1'b1, 1'b0);
        for (int i = 1; i < 6; i++) send(8'h10 + 8'(i), 1'b0, 1'b0);
        send(8'h16, 1'b0, 1'b1);
        wait_done(1'b1, seen);
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL over_done: got no frame_done want pulse"); end
        checks++; if (s_err !== 2'b10 || s_ok !== 1'b0 || s_len !== 3'd5) begin failures++; $display("FAIL over_result: got err=%b ok=%b len=%0d want 10/0/5", s_err, s_ok, s_len); end
        idle(1);
        checks++; if (s_pl_q.size() !== 4) begin failures++; $display("FAIL over_pl_count: got %0d want 4", s_pl_q.size()); end
        for (int i = 0; i < 4 && i < s_pl_q.size(); i++) begin
            exp_b = 8'h10 + 8'(i);
            checks++; if (s_pl_q[i] !== exp_b) begin failures++; $display("FAIL over_pl_byte%0d: got %h want %h", i, s_pl_q[i], exp_b); end
        end
        send(8'hFF, 1'b1, 1'b0);
        send(8'hFF, 1'b0, 1'b1);
        wait_done(1'b1, seen);
        checks++; if (seen !== 1'b1 || s_ok !== 1'b1 || s_err !== 2'b00) begin failures++; $display("FAIL over_next_good: got seen=%b ok=%b err=%b want 1/1/00", seen, s_ok, s_err); end
        idle(1);
    endtask

    task automatic test_abort;
        bit seen;
        send(8'h31, 1'b1, 1'b0);
        send(8'h32, 1'b0, 1'b0);
        send(8'h33, 1'b0, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (b_done !== 1'b1 || b_err !== 2'b11 || b_ok !== 1'b0 || b_len !== 11'd1) begin failures++; $display("FAIL abort_result: got done=%b err=%b ok=%b len=%0d want 1/11/0/1", b_done, b_err, b_ok, b_len); end
        rx_valid = 1'b1; rx_data = 8'hFF; rx_sof = 1'b0; rx_eof = 1'b1;
        wait_done(1'b0, seen);
        checks++; if (seen !== 1'b1 || b_ok !== 1'b1 || b_err !== 2'b00 || b_len !== 11'd0) begin failures++; $display("FAIL abort_next_good: got seen=%b ok=%b err=%b len=%0d want 1/1/00/0", seen, b_ok, b_err, b_len); end
        idle(1);
    endtask

    task automatic test_reset_midframe;
        bit seen;
        int base;
        send(8'h41, 1'b1, 1'b0);
        send(8'h42, 1'b0, 1'b0);
        send(8'h43, 1'b0, 1'b0);
        send(8'h44, 1'b0, 1'b0);
        @(negedge clk);
        rx_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        b_pl_q.delete();
        checks++; if ({b_pl_valid, b_done, b_ok, b_err} !== 5'b00000 || b_len !== 11'd0 || b_calc !== 16'h0000) begin failures++; $display("FAIL rst_mid_outputs: got pv=%b done=%b ok=%b err=%b len=%0d calc=%h want all 0", b_pl_valid, b_done, b_ok, b_err, b_len, b_calc); end
        @(negedge clk);
        reset_n = 1'b1;
        base = b_done_cnt;
        send(8'h45, 1'b0, 1'b1);
        idle(4);
        checks++; if (b_done_cnt !== base || b_pl_q.size() !== 0) begin failures++; $display("FAIL rst_mid_quiet: got dones=%0d pl=%0d want 0/0", b_done_cnt - base, b_pl_q.size()); end
        send(8'hFF, 1'b1, 1'b0);
        send(8'hFF, 1'b0, 1'b1);
        wait_done(1'b0, seen);
        checks++; if (seen !== 1'b1 || b_ok !== 1'b1) begin failures++; $display("FAIL rst_mid_recover: got seen=%b ok=%b want 1/1", seen, b_ok); end
        idle(1);
    endtask

    task automatic test_back_to_back_err_cnt;
        int base_done;
        int base_ok;
        logic [15:0] exp_cnt;
        @(negedge clk);
        sync_reset = 1'b1;
        @(negedge clk);
        sync_reset = 1'b0;
        checks++; if (b_ok !== 1'b0 || b_len !== 11'd0 || b_calc !== 16'h0000 || b_err_cnt !== 16'h0000) begin failures++; $display("FAIL srst_clear: got ok=%b len=%0d calc=%h cnt=%h want 0/0/0000/0000", b_ok, b_len, b_calc, b_err_cnt); end
        b_pl_q.delete();
        base_done = b_done_cnt;
        base_ok   = b_ok_cnt;
        send(msg[0], 1'b1, 1'b0);
        for (int i = 1; i < 9; i++) send(msg[i], 1'b0, 1'b0);
        send(8'h29, 1'b0, 1'b0);
        send(8'hB0, 1'b0, 1'b1);
        send(8'h55, 1'b1, 1'b1);
        send(8'hFF, 1'b1, 1'b0);
        send(8'hFE, 1'b0, 1'b1);
        send(8'hFF, 1'b1, 1'b0);
        send(8'hFF, 1'b0, 1'b1);
        send(msg[0], 1'b1, 1'b0);
        for (int i = 1; i < 9; i++) send(msg[i], 1'b0, 1'b0);
        send(8'h29, 1'b0, 1'b0);
        send(8'hB1, 1'b0, 1'b1);
        idle(4);
`ifdef CRC_CHK_ERR_CNT_EN
        exp_cnt = 16'd3;
`else
        exp_cnt = 16'd0;
`endif
        checks++; if (b_done_cnt - base_done !== 5) begin failures++; $display("FAIL b2b_dones: got %0d want 5", b_done_cnt - base_done); end
        checks++; if (b_ok_cnt - base_ok !== 2) begin failures++; $display("FAIL b2b_ok_frames: got %0d want 2", b_ok_cnt - base_ok); end
        checks++; if (b_pl_q.size() !== 18) begin failures++; $display("FAIL b2b_pl_count: got %0d want 18", b_pl_q.size()); end
        checks++; if (b_err_cnt !== exp_cnt) begin failures++; $display("FAIL err_cnt: got %0d want %0d", b_err_cnt, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_crc();
        test_zero_payload_and_runt();
        test_overlength();
        test_abort();
        test_reset_midframe();
        test_back_to_back_err_cnt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
